branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the five-stage RV32I pipeline. It generalises the fixed predict-taken/valid pair that fetch drives today into a tagged branch target buffer (BTB) plus a saturating-counter pattern history table (PHT), both configurable in depth and counter width. Fetch looks it up combinationally on PC_F. Resolved branches and jumps in execute update it on the clock edge. An internal shadow pipeline carries the lookup index from fetch to execute, so that stalls and flushes are honoured.

## Interface
- ENTRIES, 64: BTB and PHT depth; power of two, ≥4; IDX_W = $clog2(ENTRIES)
- CTR_W, 2: PHT counter width, 1..4
- TAG_W, 8: BTB tag width; tag = PC[TAG_W+IDX_W+1 : IDX_W+2]
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- PC_F  in  32  fetch PC to look up
- Stall_En  in  1  hazard unit stall (holds the D shadow stage)
- Flush_D  in  1  invalidates the D shadow stage
- Flush_E  in  1  invalidates the E shadow stage
- PC_E  in  32  PC of the instruction in execute
- Branch_En_E  in  1  conditional branch in execute
- Jump_En_E  in  1  JAL/JALR in execute
- Branch_Taken_E  in  1  resolved direction
- PC_Target_E  in  32  resolved target
- Valid_F  out  1  BTB hit for PC_F
- Predict_Taken_F  out  1  predicted redirect
- Target_F  out  32  predicted target

## Operation
- BTB entry fields: valid, jump, tag[TAG_W], target[32]. Index = PC[IDX_W+1:2].
- PHT entry: unsigned counter[CTR_W]. Index pht_idx_F = PC_F[IDX_W+1:2], XORed with the GHR when gshare is enabled.
- Lookup is combinational:
  - hit = valid && tag == tag(PC_F)
  - Valid_F = hit
  - Predict_Taken_F = hit && (jump || counter MSB)
  - Target_F = stored target; 0 when there is no hit
- Shadow pipeline registers {pht_idx, v}:
  - D stage: Flush_D → v=0; else Stall_En → hold; else capture {pht_idx_F, 1}.
  - E stage: Flush_E → v=0; else capture D.
  - Flush has priority over stall.
- Update fires when Branch_En_E || Jump_En_E. The BTB index and tag come from PC_E. The PHT index comes from the E shadow stage.
  - Jump: write valid=1, jump=1, tag, target. PHT unchanged.
  - Branch, BTB hit: saturating +1 when taken, −1 when not taken; clamps at 0 and 2^CTR_W−1. Target is overwritten with PC_Target_E when taken.
  - Branch, BTB miss, taken: allocate with valid=1, jump=0, tag, target. PHT set to weakly-taken, 2^(CTR_W−1).
  - Branch, BTB miss, not taken: no change.
- An update is ignored if Branch_En_E and Jump_En_E are both high. This is an illegal encoding and is flagged by an assertion.
- An update while the E shadow v=0 is a protocol error and is flagged by an assertion. The PHT still updates using the stale index.

## Timing
- Lookup latency is 0 cycles: PC_F to outputs is combinational from registered state.
- Update latency is 1 edge: it is visible to a lookup in the following cycle.
- Same-cycle read and write to the same entry returns the pre-update value; there is no bypass.
- Reset (asynchronous, effective immediately and mid-operation):
  - all BTB valid=0, targets=0
  - PHT = weakly-not-taken, 2^(CTR_W−1)−1
  - GHR = 0
  - shadow v=0
  - outputs Valid_F=0, Predict_Taken_F=0, Target_F=0
- Aliasing: same index with a different tag is a miss, and the entry is replaced on a taken allocation.

## Configuration
- BP_GSHARE_EN defined:
  - IDX_W-bit global history register (GHR).
  - On each Branch_En_E update, GHR ← {GHR[IDX_W−2:0], Branch_Taken_E}.
  - Jumps do not shift the GHR.
  - pht_idx_F = PC_F[IDX_W+1:2] ^ GHR.
  - The GHR is non-speculative; the shadow pipeline guarantees the update uses the lookup-time index.
- BP_GSHARE_EN undefined: no GHR; pht_idx_F = PC_F[IDX_W+1:2].

## Structure
- Shared package bp_pkg:
  - btb_entry_t struct
  - counter reset and weakly-taken constants as functions of CTR_W
  - sat_inc / sat_dec functions
- Sub-module bp_index_pipe: the D/E shadow registers with stall/flush priority.

## Test plan
All scenarios use ENTRIES=64, CTR_W=2, TAG_W=8.
- Reset: assert RST mid-run, then PC_F=0x100 → Valid_F=0, Predict_Taken_F=0, Target_F=0.
- Allocate: branch at PC_E=0x100, taken, PC_Target_E=0x80 → next cycle, PC_F=0x100 gives Valid_F=1, Predict_Taken_F=1, Target_F=0x80, counter=2.
- Saturation: three not-taken updates at 0x100 → counter 2→1→0→0, Predict_Taken_F=0, Valid_F=1; four taken updates → counter 3, held.
- Alias and jump: PC_F=0x1100 → Valid_F=0. JAL at 0x200 to 0x300 → PC_F=0x200 gives Predict_Taken_F=1, Target_F=0x300 regardless of counter.
- Shadow pipeline: lookup at 0x100, Stall_En high for 2 cycles then Flush_D → E shadow v never 1. Unflushed lookup → E index equals 0x00.
- Gshare (BP_GSHARE_EN): three taken branches → GHR=0b000111. PC_F=0x100 then indexes PHT entry 0x07.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor.
// Counter helpers take the live counter width so one package serves every CTR_W.
package bp_pkg;

  localparam int unsigned TAG_MAX_W = 30;
  localparam int unsigned CTR_MAX_W = 4;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  typedef struct packed {
    logic                 valid;
    logic                 jump;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((1 << w) - 1);
  endfunction

  function automatic ctr_t ctr_weak_taken(input int unsigned w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_weak_not_taken(input int unsigned w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t c, input int unsigned w);
    return (c >= ctr_max(w)) ? c : ctr_t'(c + 4'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == '0) ? c : ctr_t'(c - 4'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-update bundle between the pipeline and the branch predictor.
interface branch_predictor_if;
  logic [31:0] PC_F;
  logic        Stall_En;
  logic        Flush_D;
  logic        Flush_E;
  logic [31:0] PC_E;
  logic        Branch_En_E;
  logic        Jump_En_E;
  logic        Branch_Taken_E;
  logic [31:0] PC_Target_E;
  logic        Valid_F;
  logic        Predict_Taken_F;
  logic [31:0] Target_F;

  modport master (
    output PC_F, Stall_En, Flush_D, Flush_E, PC_E,
           Branch_En_E, Jump_En_E, Branch_Taken_E, PC_Target_E,
    input  Valid_F, Predict_Taken_F, Target_F
  );

  modport slave (
    input  PC_F, Stall_En, Flush_D, Flush_E, PC_E,
           Branch_En_E, Jump_En_E, Branch_Taken_E, PC_Target_E,
    output Valid_F, Predict_Taken_F, Target_F
  );
endinterface

// File: rtl/bp_index_pipe.sv
// D/E shadow registers carrying the fetch-time PHT index to execute.
// Flush wins over stall in D; E simply follows D unless flushed.
module bp_index_pipe #(
  parameter int unsigned IDX_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall_en,
  input  logic             flush_d,
  input  logic             flush_e,
  input  logic [IDX_W-1:0] idx_f,
  output logic [IDX_W-1:0] idx_e,
  output logic             v_e
);

  logic [IDX_W-1:0] idx_d;
  logic             v_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_d <= '0;
      v_d   <= 1'b0;
    end else if (flush_d) begin
      v_d   <= 1'b0;
    end else if (!stall_en) begin
      idx_d <= idx_f;
      v_d   <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_e <= '0;
      v_e   <= 1'b0;
    end else if (flush_e) begin
      v_e   <= 1'b0;
    end else begin
      idx_e <= idx_d;
      v_e   <= v_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BTB plus saturating-counter PHT; combinational lookup in fetch, update from execute.
// Optional gshare indexing (global history XOR PC) is enabled by defining BP_GSHARE_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8
) (
  input  logic         CLK,
  input  logic         RST,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_weak_not_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));

  btb_entry_t       btb [ENTRIES];
  logic [CTR_W-1:0] pht [ENTRIES];

  logic [IDX_W-1:0]     f_idx;
  logic [TAG_MAX_W-1:0] f_tag;
  logic [IDX_W-1:0]     pht_idx_f;
  btb_entry_t           f_ent;
  logic [CTR_W-1:0]     f_ctr;
  logic                 f_hit;

  logic [IDX_W-1:0]     e_idx;
  logic [TAG_MAX_W-1:0] e_tag;
  logic [IDX_W-1:0]     pht_idx_e;
  logic                 v_e;
  btb_entry_t           e_ent;
  logic                 e_hit;
  logic                 br_upd;
  logic                 jmp_upd;
  logic [CTR_W-1:0]     e_ctr;

  assign f_idx = bp.PC_F[IDX_W+1:2];
  assign f_tag = TAG_MAX_W'(bp.PC_F[TAG_W+IDX_W+1:IDX_W+2]);
  assign e_idx = bp.PC_E[IDX_W+1:2];
  assign e_tag = TAG_MAX_W'(bp.PC_E[TAG_W+IDX_W+1:IDX_W+2]);

  // Both enables high is an illegal encoding and updates nothing
  assign br_upd  = bp.Branch_En_E && !bp.Jump_En_E;
  assign jmp_upd = bp.Jump_En_E && !bp.Branch_En_E;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Non-speculative history: shifted only by resolved conditional branches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ghr <= '0;
    end else if (br_upd) begin
      ghr <= {ghr[IDX_W-2:0], bp.Branch_Taken_E};
    end
  end

  assign pht_idx_f = f_idx ^ ghr;
`else
  assign pht_idx_f = f_idx;
`endif

  // Fetch lookup from registered state only
  assign f_ent = btb[f_idx];
  assign f_ctr = pht[pht_idx_f];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

  assign bp.Valid_F         = f_hit;
  assign bp.Predict_Taken_F = f_hit && (f_ent.jump || f_ctr[CTR_W-1]);
  assign bp.Target_F        = f_hit ? f_ent.target : 32'h0;

  bp_index_pipe #(.IDX_W(IDX_W)) u_pipe (
    .CLK      (CLK),
    .RST      (RST),
    .stall_en (bp.Stall_En),
    .flush_d  (bp.Flush_D),
    .flush_e  (bp.Flush_E),
    .idx_f    (pht_idx_f),
    .idx_e    (pht_idx_e),
    .v_e      (v_e)
  );

  assign e_ent = btb[e_idx];
  assign e_hit = e_ent.valid && (e_ent.tag == e_tag);
  assign e_ctr = pht[pht_idx_e];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (jmp_upd) begin
      btb[e_idx] <= '{valid: 1'b1, jump: 1'b1, tag: e_tag, target: bp.PC_Target_E};
    end else if (br_upd && bp.Branch_Taken_E) begin
      if (e_hit) begin
        btb[e_idx].target <= bp.PC_Target_E;
      end else begin
        btb[e_idx] <= '{valid: 1'b1, jump: 1'b0, tag: e_tag, target: bp.PC_Target_E};
      end
    end
  end

  // PHT uses the fetch-time index carried by the shadow pipe, even if stale
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= CTR_RST;
    end else if (br_upd) begin
      if (e_hit) begin
        pht[pht_idx_e] <= bp.Branch_Taken_E ? CTR_W'(sat_inc(ctr_t'(e_ctr), CTR_W))
                                            : CTR_W'(sat_dec(ctr_t'(e_ctr)));
      end else if (bp.Branch_Taken_E) begin
        pht[pht_idx_e] <= CTR_WT;
      end
    end
  end

  ap_legal_enc: assert property (@(posedge CLK) disable iff (RST)
    !(bp.Branch_En_E && bp.Jump_En_E));

  ap_shadow_valid: assert property (@(posedge CLK) disable iff (RST)
    (bp.Branch_En_E || bp.Jump_En_E) |-> v_e);

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against an array-based reference model.
module tb_branch_predictor;

  localparam int NENT = 64;
  localparam int CMAX = 3;
  localparam int CWT  = 2;
  localparam int CWNT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  bit          m_v  [NENT];
  bit          m_j  [NENT];
  int          m_t  [NENT];
  logic [31:0] m_tg [NENT];
  int          m_c  [NENT];
  int          m_ghr;

  branch_predictor_if bpi ();

  branch_predictor #(.ENTRIES(64), .CTR_W(2), .TAG_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bp  (bpi)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_err);
    $fatal(1);
  end

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction

  function automatic int tg(input logic [31:0] pc);
    return int'((pc >> 8) & 32'hff);
  endfunction

  function automatic int pidx(input logic [31:0] pc);
    return ix(pc) ^ m_ghr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_v[i] = 1'b0; m_j[i] = 1'b0; m_t[i] = 0; m_tg[i] = 32'h0; m_c[i] = CWNT;
    end
    m_ghr = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic v, output logic p,
                              output logic [31:0] t);
    int  i;
    bit  hit;
    i   = ix(pc);
    hit = m_v[i] && (m_t[i] == tg(pc));
    v   = hit;
    p   = hit && (m_j[i] || (m_c[pidx(pc)] >= CWT));
    t   = hit ? m_tg[i] : 32'h0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic br, input logic jmp,
                              input logic tk, input logic [31:0] tgt, input int pi);
    int i;
    bit hit;
    i   = ix(pc);
    hit = m_v[i] && (m_t[i] == tg(pc));
    if (br && jmp) return;
    if (jmp) begin
      m_v[i] = 1'b1; m_j[i] = 1'b1; m_t[i] = tg(pc); m_tg[i] = tgt;
    end else if (br) begin
      if (hit) begin
        if (tk) begin
          m_c[pi] = (m_c[pi] < CMAX) ? m_c[pi] + 1 : CMAX;
          m_tg[i] = tgt;
        end else begin
          m_c[pi] = (m_c[pi] > 0) ? m_c[pi] - 1 : 0;
        end
      end else if (tk) begin
        m_v[i] = 1'b1; m_j[i] = 1'b0; m_t[i] = tg(pc); m_tg[i] = tgt; m_c[pi] = CWT;
      end
`ifdef BP_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(tk)) & (NENT - 1);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bpi.Stall_En = 1'b0; bpi.Flush_D = 1'b0; bpi.Flush_E = 1'b0;
    bpi.Branch_En_E = 1'b0; bpi.Jump_En_E = 1'b0; bpi.Branch_Taken_E = 1'b0;
    bpi.PC_E = 32'h0; bpi.PC_Target_E = 32'h0;
  endtask

  // Fetch pc, let it travel D->E, then resolve it in execute
  task automatic issue(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt);
    int pi;
    pi = pidx(pc);
    bpi.PC_F = pc;
    tick();
    bpi.PC_F = 32'h0;
    tick();
    bpi.PC_E = pc; bpi.Branch_En_E = br; bpi.Jump_En_E = jmp;
    bpi.Branch_Taken_E = tk; bpi.PC_Target_E = tgt;
    tick();
    model_update(pc, br, jmp, tk, tgt, pi);
    clear_ctrl();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic v, p;
    logic [31:0] t;
    model_reset();
    bpi.PC_F = 32'h100;
    tick();
    model_lookup(32'h100, v, p, t);
    n_vec++; if (bpi.Valid_F !== 1'b0 || v !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bpi.Valid_F); end
    n_vec++; if (bpi.Predict_Taken_F !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b expected 0", bpi.Predict_Taken_F); end
    n_vec++; if (bpi.Target_F !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h expected 0", bpi.Target_F); end
    n_vec++; if (int'(dut.pht[5]) !== CWNT) begin n_err++; $display("FAIL reset_ctr: got %0d expected %0d", dut.pht[5], CWNT); end
    n_vec++; if (dut.u_pipe.v_e !== 1'b0) begin n_err++; $display("FAIL reset_shadow_v: got %b expected 0", dut.u_pipe.v_e); end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_lookup(input logic [31:0] pc, input string name);
    logic v, p;
    logic [31:0] t;
    int k;
    bpi.PC_F = pc;
    #1;
    model_lookup(pc, v, p, t);
    k = pidx(pc);
    n_vec++; if (bpi.Valid_F !== v) begin n_err++; $display("FAIL %s_valid: got %b expected %b", name, bpi.Valid_F, v); end
    n_vec++; if (bpi.Predict_Taken_F !== p) begin n_err++; $display("FAIL %s_pred: got %b expected %b", name, bpi.Predict_Taken_F, p); end
    n_vec++; if (bpi.Target_F !== t) begin n_err++; $display("FAIL %s_target: got %h expected %h", name, bpi.Target_F, t); end
    n_vec++; if (int'(dut.pht[k]) !== m_c[k]) begin n_err++; $display("FAIL %s_ctr: got %0d expected %0d", name, dut.pht[k], m_c[k]); end
  endtask

  task automatic test_allocate();
    issue(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    check_lookup(32'h100, "alloc");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 3; n++) begin
      issue(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      check_lookup(32'h100, "sat_down");
    end
    for (int n = 0; n < 4; n++) begin
      issue(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
      check_lookup(32'h100, "sat_up");
    end
  endtask

  task automatic test_alias_jump();
    check_lookup(32'h1100, "alias");
    issue(32'h200, 1'b0, 1'b1, 1'b1, 32'h300);
    check_lookup(32'h200, "jal");
    check_lookup(32'h100, "replaced");
    for (int n = 0; n < 3; n++) begin
      issue(32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
      check_lookup(32'h200, "jal_nt");
    end
  endtask

  task automatic test_shadow();
    do_reset();
    bpi.PC_F = 32'h100; bpi.Flush_E = 1'b1;
    tick();
    n_vec++; if (dut.u_pipe.v_e !== 1'b0) begin n_err++; $display("FAIL shadow_e0: got %b expected 0", dut.u_pipe.v_e); end
    bpi.Stall_En = 1'b1; bpi.PC_F = 32'h104;
    for (int n = 0; n < 2; n++) begin
      tick();
      n_vec++; if (dut.u_pipe.v_e !== 1'b0) begin n_err++; $display("FAIL shadow_stall_e: got %b expected 0", dut.u_pipe.v_e); end
      n_vec++; if (int'(dut.u_pipe.idx_d) !== ix(32'h100)) begin n_err++; $display("FAIL shadow_hold: got %0d expected %0d", dut.u_pipe.idx_d, ix(32'h100)); end
    end
    bpi.Flush_D = 1'b1;
    tick();
    n_vec++; if (dut.u_pipe.v_d !== 1'b0) begin n_err++; $display("FAIL shadow_flush_d: got %b expected 0", dut.u_pipe.v_d); end
    n_vec++; if (dut.u_pipe.v_e !== 1'b0) begin n_err++; $display("FAIL shadow_flush_e: got %b expected 0", dut.u_pipe.v_e); end
    clear_ctrl();
    bpi.PC_F = 32'h100;
    tick();
    n_vec++; if (dut.u_pipe.v_e !== 1'b0) begin n_err++; $display("FAIL shadow_drain: got %b expected 0", dut.u_pipe.v_e); end
    bpi.PC_F = 32'h4;
    tick();
    n_vec++; if (dut.u_pipe.v_e !== 1'b1) begin n_err++; $display("FAIL shadow_e_valid: got %b expected 1", dut.u_pipe.v_e); end
    n_vec++; if (int'(dut.u_pipe.idx_e) !== pidx(32'h100)) begin n_err++; $display("FAIL shadow_e_idx: got %0d expected %0d", dut.u_pipe.idx_e, pidx(32'h100)); end
  endtask

  task automatic test_gshare();
`ifdef BP_GSHARE_EN
    do_reset();
    issue(32'h104, 1'b1, 1'b0, 1'b1, 32'h40);
    issue(32'h108, 1'b1, 1'b0, 1'b1, 32'h44);
    issue(32'h10c, 1'b1, 1'b0, 1'b1, 32'h48);
    n_vec++; if (int'(dut.ghr) !== m_ghr || m_ghr !== 7) begin n_err++; $display("FAIL gshare_ghr: got %0d expected 7", dut.ghr); end
    bpi.PC_F = 32'h100;
    #1;
    n_vec++; if (int'(dut.pht_idx_f) !== pidx(32'h100)) begin n_err++; $display("FAIL gshare_idx: got %0d expected %0d", dut.pht_idx_f, pidx(32'h100)); end
    check_lookup(32'h10c, "gshare");
`endif
  endtask

  task automatic test_back_to_back();
    localparam int N = 400;
    logic [31:0] pcs [N];
    logic [31:0] tgs [N];
    logic        brs [N];
    logic        jps [N];
    logic        tks [N];
    int          pis [N];
    logic        v, p;
    logic [31:0] t;
    int          r;
    for (int k = 0; k < N; k++) begin
      pcs[k] = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      r      = int'($urandom_range(0, 9));
      brs[k] = (r < 6);
      jps[k] = (r == 6 || r == 7);
      tks[k] = 1'($urandom_range(0, 1));
      tgs[k] = $urandom & 32'hffff_fffc;
      pis[k] = pidx(pcs[k]);
      bpi.PC_F = pcs[k];
      if (k >= 2) begin
        bpi.PC_E = pcs[k-2]; bpi.Branch_En_E = brs[k-2]; bpi.Jump_En_E = jps[k-2];
        bpi.Branch_Taken_E = tks[k-2]; bpi.PC_Target_E = tgs[k-2];
      end else begin
        clear_ctrl();
      end
      #1;
      model_lookup(pcs[k], v, p, t);
      n_vec++; if (bpi.Valid_F !== v) begin n_err++; $display("FAIL b2b_valid @%0d: got %b expected %b", k, bpi.Valid_F, v); end
      n_vec++; if (bpi.Predict_Taken_F !== p) begin n_err++; $display("FAIL b2b_pred @%0d: got %b expected %b", k, bpi.Predict_Taken_F, p); end
      n_vec++; if (bpi.Target_F !== t) begin n_err++; $display("FAIL b2b_target @%0d: got %h expected %h", k, bpi.Target_F, t); end
      tick();
      if (k >= 2) model_update(pcs[k-2], brs[k-2], jps[k-2], tks[k-2], tgs[k-2], pis[k-2]);
    end
    clear_ctrl();
  endtask

  task automatic test_midrun_reset();
    issue(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    bpi.PC_F = 32'h100;
    #1;
    n_vec++; if (bpi.Valid_F !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b expected 1", bpi.Valid_F); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (bpi.Valid_F !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", bpi.Valid_F); end
    n_vec++; if (bpi.Predict_Taken_F !== 1'b0) begin n_err++; $display("FAIL midrst_pred: got %b expected 0", bpi.Predict_Taken_F); end
    n_vec++; if (bpi.Target_F !== 32'h0) begin n_err++; $display("FAIL midrst_target: got %h expected 0", bpi.Target_F); end
    tick();
    rst = 1'b0;
    model_reset();
    check_lookup(32'h100, "post_rst");
  endtask

  initial begin
    bpi.PC_F = 32'h0;
    clear_ctrl();
    test_reset();
    test_allocate();
    test_saturation();
    test_alias_jump();
    test_shadow();
    test_gshare();
    test_back_to_back();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
